tile_draw_scheduler: RTL and testbench

Sequences the single tile-drawer engine on behalf of up to NUM_REQ requesters, such as the background painter, the player sprite and UI overlays. It arbitrates requests round-robin and latches the winner's tile index and position. It then launches one 8x8 tile draw and tracks the drawer's active signal until the tile completes. It sits between game logic and the drawer, so only one tile draw ever owns the shared VGA write bus.

---
 rtl/tile_sched_pkg.sv | 22 ++
 rtl/tile_draw_scheduler_rr_arbiter.sv | 32 +++
 rtl/tile_draw_scheduler.sv | 137 +++++++++++++
 tb/tb_tile_draw_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_sched_pkg.sv
// Shared types and defaults for the tile draw scheduler and its arbiter.
package tile_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_LAUNCH     = 3'd1,
      ST_WAIT_START = 3'd2,
      ST_WAIT_DONE  = 3'd3,
      ST_DONE       = 3'd4
   } sched_state_t;

   localparam int TILE_WORDS_DEF    = 192;
   localparam int START_TIMEOUT_DEF = 7;
   localparam int TILE_ADDR_W       = 12;

   // ROM base of a tile; wraps silently beyond the 12-bit ROM space.
   function automatic logic [TILE_ADDR_W-1:0] tile_base(input int unsigned idx,
                                                        input int unsigned words);
      return TILE_ADDR_W'(idx * words);
   endfunction

endpackage

// File: rtl/tile_draw_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter
   import tile_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic [PTR_W-1:0]   winner_idx,
   output logic               valid
);

   int unsigned slot;

   always_comb begin
      winner     = '0;
      winner_idx = '0;
      valid      = 1'b0;
      slot       = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         slot = (int'(ptr) + i) % NUM_REQ;
         if (!valid && req[slot]) begin
            valid        = 1'b1;
            winner[slot] = 1'b1;
            winner_idx   = PTR_W'(slot);
         end
      end
   end

endmodule

// File: rtl/tile_draw_scheduler.sv
// Round-robin scheduler owning the single tile drawer; one 8x8 tile in flight at a time.
// Define TILE_DRAW_COUNT_EN to build the completed-tile counter on tiles_drawn.
//
// state         | meaning
// IDLE          | waiting for enable, a request and an idle drawer
// LAUNCH        | winner latched, grant pulsing; drw_draw issued next
// WAIT_START    | drw_draw pulsing, waiting for drw_active to rise (timed)
// WAIT_DONE     | drawer running, waiting for drw_active to fall
// DONE          | one cycle of completion bookkeeping
module tile_draw_scheduler
   import tile_sched_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int IDX_W         = 4,
   parameter int TILE_WORDS    = TILE_WORDS_DEF,
   parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     enable,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*IDX_W-1:0] req_idx,
   input  logic [NUM_REQ*8-1:0]     req_x,
   input  logic [NUM_REQ*8-1:0]     req_y,
   output logic [NUM_REQ-1:0]       grant,
   output logic [TILE_ADDR_W-1:0]   drw_tile_address,
   output logic [7:0]               drw_x,
   output logic [7:0]               drw_y,
   output logic                     drw_draw,
   input  logic                     drw_active,
   output logic                     busy,
   output logic                     timeout_err,
   output logic [15:0]              tiles_drawn
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(START_TIMEOUT + 1);

   sched_state_t state, state_nxt;

   logic [NUM_REQ-1:0] win_onehot;
   logic [PTR_W-1:0]   win_idx;
   logic               win_valid;
   logic [PTR_W-1:0]   rr;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_inc;
   logic               start_expired;
   logic               do_grant;
   logic               do_launch;
   logic               do_abort;
   logic               do_count;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
      .req        (req),
      .ptr        (rr),
      .winner     (win_onehot),
      .winner_idx (win_idx),
      .valid      (win_valid)
   );

   assign cnt_inc       = cnt + 1'b1;
   assign start_expired = (cnt_inc == CNT_W'(START_TIMEOUT));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // A drawer already active in IDLE belongs to someone else; hold off grants.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:       if (enable && win_valid && !drw_active) state_nxt = ST_LAUNCH;
         ST_LAUNCH:     state_nxt = ST_WAIT_START;
         ST_WAIT_START: begin
            if (drw_active)         state_nxt = ST_WAIT_DONE;
            else if (start_expired) state_nxt = ST_IDLE;
         end
         ST_WAIT_DONE:  if (!drw_active) state_nxt = ST_DONE;
         ST_DONE:       state_nxt = ST_IDLE;
         default:       state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      do_grant  = (state == ST_IDLE) && (state_nxt == ST_LAUNCH);
      do_launch = (state == ST_LAUNCH);
      do_abort  = (state == ST_WAIT_START) && !drw_active && start_expired;
      do_count  = (state == ST_DONE);
   end

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         grant            <= '0;
         drw_draw         <= 1'b0;
         drw_tile_address <= '0;
         drw_x            <= '0;
         drw_y            <= '0;
         rr               <= '0;
         cnt              <= '0;
         timeout_err      <= 1'b0;
      end else begin
         grant    <= do_grant ? win_onehot : '0;
         drw_draw <= do_launch;
         if (do_grant) begin
            drw_tile_address <= tile_base(int'(req_idx[win_idx*IDX_W +: IDX_W]), TILE_WORDS);
            drw_x            <= req_x[win_idx*8 +: 8];
            drw_y            <= req_y[win_idx*8 +: 8];
            rr               <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
         end
         if (do_launch)
            cnt <= '0;
         else if (state == ST_WAIT_START && !drw_active)
            cnt <= cnt_inc;
         if (do_abort)
            timeout_err <= 1'b1;
      end
   end

`ifdef TILE_DRAW_COUNT_EN
   logic [15:0] tile_cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)       tile_cnt <= '0;
      else if (do_count) tile_cnt <= tile_cnt + 16'd1;
   end

   assign tiles_drawn = tile_cnt;
`else
   logic unused_count;
   assign unused_count = do_count;
   assign tiles_drawn  = '0;
`endif

endmodule

// File: tb/tb_tile_draw_scheduler.sv
// Directed and randomized bench for tile_draw_scheduler against a transaction-level model.
module tb_tile_draw_scheduler;

   logic        clk = 1'b0;
   logic        resetn, enable, drw_active;
   logic [3:0]  req;
   logic [15:0] req_idx;
   logic [31:0] req_x, req_y;

   logic [3:0]  grant, grant_b;
   logic [11:0] addr, addr_b;
   logic [7:0]  dx, dy, dx_b, dy_b;
   logic        draw, draw_b, busy, busy_b, err, err_b;
   logic [15:0] tiles, tiles_b;

   tile_draw_scheduler #(.NUM_REQ(4), .IDX_W(4), .TILE_WORDS(192), .START_TIMEOUT(7)) u_dut (
      .clk(clk), .resetn(resetn), .enable(enable), .req(req), .req_idx(req_idx),
      .req_x(req_x), .req_y(req_y), .grant(grant), .drw_tile_address(addr),
      .drw_x(dx), .drw_y(dy), .drw_draw(draw), .drw_active(drw_active),
      .busy(busy), .timeout_err(err), .tiles_drawn(tiles)
   );

   tile_draw_scheduler #(.NUM_REQ(4), .IDX_W(4), .TILE_WORDS(300), .START_TIMEOUT(7)) u_dut300 (
      .clk(clk), .resetn(resetn), .enable(enable), .req(req), .req_idx(req_idx),
      .req_x(req_x), .req_y(req_y), .grant(grant_b), .drw_tile_address(addr_b),
      .drw_x(dx_b), .drw_y(dy_b), .drw_draw(draw_b), .drw_active(drw_active),
      .busy(busy_b), .timeout_err(err_b), .tiles_drawn(tiles_b)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int m_rr = 0;
   int m_tiles = 0;
   bit m_err = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int pick(input logic [3:0] r);
      for (int i = 0; i < 4; i++)
         if (r[(m_rr + i) % 4]) return (m_rr + i) % 4;
      return -1;
   endfunction

   function automatic int exp_tiles();
`ifdef TILE_DRAW_COUNT_EN
      return m_tiles % 65536;
`else
      return 0;
`endif
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_grant"}, grant, 0);
      check({tag, "_addr"}, addr, 0);
      check({tag, "_x"}, dx, 0);
      check({tag, "_y"}, dy, 0);
      check({tag, "_draw"}, draw, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_tiles"}, tiles, 0);
      check({tag, "_b"}, {grant_b, addr_b, dx_b, dy_b, draw_b, busy_b}, 0);
      check({tag, "_b_st"}, {err_b, tiles_b}, 0);
   endtask

   // mode: 0 normal, 1 drop enable mid-draw, 2 reset mid-draw, 3 drawer never starts
   task automatic do_tile(input int mode, input int act_len);
      int w;
      int ei;
      logic [7:0] ex, ey;
      w = pick(req);
      if (w < 0 || !enable || drw_active) begin
         tick();
         check("idle_grant", grant, 0);
         check("idle_busy", busy, 0);
         return;
      end
      ei = int'(req_idx[w*4 +: 4]);
      ex = req_x[w*8 +: 8];
      ey = req_y[w*8 +: 8];
      tick();
      m_rr = (w + 1) % 4;
      check("grant", grant, 32'(1) << w);
      check("grant_b", grant_b, 32'(1) << w);
      check("addr", addr, (ei * 192) % 4096);
      check("addr_300", addr_b, (ei * 300) % 4096);
      check("x", dx, ex);
      check("y", dy, ey);
      check("x_b", dx_b, ex);
      check("y_b", dy_b, ey);
      check("draw_early", draw, 0);
      check("busy_grant", busy, 1);
      req = 4'($urandom);
      req_idx = 16'($urandom);
      req_x = $urandom;
      req_y = $urandom;
      tick();
      check("draw", draw, 1);
      check("draw_b", draw_b, 1);
      check("grant_once", grant, 0);
      if (mode == 3) begin
         repeat (6) begin
            tick();
            check("err_pre", err, 32'(m_err));
            check("busy_wait", busy, 1);
         end
         tick();
         m_err = 1'b1;
         check("err_set", err, 1);
         check("err_set_b", err_b, 1);
         check("busy_abort", busy, 0);
         check("tiles_abort", tiles, exp_tiles());
         return;
      end
      drw_active = 1'b1;
      tick();
      check("draw_pulse", draw, 0);
      check("busy_run", busy, 1);
      if (mode == 1) begin
         enable = 1'b0;
         req = 4'b0010;
      end
      if (mode == 2) begin
         #2 resetn = 1'b0;
         #1;
         m_rr = 0;
         m_tiles = 0;
         m_err = 1'b0;
         check_all_zero("rst_mid");
         drw_active = 1'b0;
         tick();
         resetn = 1'b1;
         return;
      end
      repeat (act_len) tick();
      check("busy_active", busy, 1);
      check("addr_hold", addr, (ei * 192) % 4096);
      check("x_hold", dx, ex);
      drw_active = 1'b0;
      tick();
      check("busy_done", busy, 1);
      tick();
      m_tiles++;
      check("busy_end", busy, 0);
      check("tiles", tiles, exp_tiles());
      check("tiles_b", tiles_b, exp_tiles());
      check("err_keep", err, 32'(m_err));
      check("err_keep_b", err_b, 32'(m_err));
   endtask

   initial begin
      resetn = 1'b0;
      enable = 1'b0;
      drw_active = 1'b0;
      req = '0;
      req_idx = '0;
      req_x = '0;
      req_y = '0;
      repeat (2) tick();
      check_all_zero("reset");
      resetn = 1'b1;
      enable = 1'b1;
      tick();

      // single request, idx 2 at (16,24), 40-cycle drawer
      req = 4'b0001;
      req_idx = 16'h0002;
      req_x = 32'd16;
      req_y = 32'd24;
      do_tile(0, 40);

      for (int i = 0; i < 8; i++) begin
         req = 4'b1111;
         req_idx = 16'($urandom);
         req_x = $urandom;
         req_y = $urandom;
         do_tile(0, 2 + i);
      end

      req = 4'b0100;
      do_tile(3, 0);
      req = 4'b0100;
      do_tile(0, 5);

      drw_active = 1'b1;
      req = 4'b0001;
      repeat (3) begin
         tick();
         check("foreign_grant", grant, 0);
         check("foreign_busy", busy, 0);
      end
      drw_active = 1'b0;
      do_tile(0, 3);

      req = 4'b0001;
      do_tile(1, 4);
      repeat (3) begin
         tick();
         check("en_grant", grant, 0);
         check("en_busy", busy, 0);
      end
      enable = 1'b1;
      req = 4'b0010;
      do_tile(0, 2);

      req = 4'b1000;
      req_idx = 16'hF000;
      do_tile(0, 1);

      req = 4'b0010;
      do_tile(2, 0);
      req = 4'b1000;
      do_tile(0, 2);
      req = 4'b1111;
      do_tile(0, 2);

      for (int i = 0; i < 30; i++) begin
         req = 4'($urandom_range(0, 15));
         req_idx = 16'($urandom);
         req_x = $urandom;
         req_y = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            #1 req = req & 4'($urandom);
         end
         do_tile(0, $urandom_range(0, 6));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
